dmem_access_unit: RTL

//  Multi-cycle load/store controller between the execute stage and the synchronous data RAM.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_load_align.sv | 26 ++
 rtl/dmem_access_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, controller states
// and the store byte-lane mask helper.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Little-endian byte-lane write enables for a store of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << off;
      SIZE_HALF: lane_mask = 4'b0011 << off;
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-path aligner: picks the addressed byte/half/word out of a RAM word and
// sign- or zero-extends it to 32 bits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_c_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    result_c_o = shifted;
    unique case (size_i)
      SIZE_BYTE: result_c_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result_c_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:   result_c_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Multi-cycle load/store controller between the execute stage and a synchronous data RAM.
// One request in flight; stores respond in two cycles, loads after the RAM read latency.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       read_data,
  output logic              err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned CNT_W     = 2;
  localparam int unsigned WAIT_INIT = (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;

  state_t             state_q;
  logic [1:0]         size_q;
  logic [1:0]         off_q;
  logic               unsigned_q;
  logic               is_load_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rsp_valid_q;
  logic               err_q;
  logic [31:0]        read_data_q;
  logic               ram_en_q;
  logic [3:0]         ram_we_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic [31:0]        ram_wdata_q;

  logic               accept;
  logic               access;
  logic               bad;
  logic [31:0]        wdata_d;
  logic [31:0]        load_result_c;
  logic               unused_addr_hi;

  assign req_ready      = (state_q == IDLE) & ~reset;
  assign accept         = req_valid & req_ready;
  assign access         = mem_read | mem_write;
  // Address bits above the RAM's byte range alias onto it.
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    bad = 1'b0;
    if (mem_read & mem_write)                          bad = 1'b1;
    else if (size == SIZE_RSVD)                        bad = 1'b1;
    else if ((size == SIZE_HALF) && addr[0])           bad = 1'b1;
    else if ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) bad = 1'b1;
  end

  // Narrow stores are replicated across lanes; the lane mask selects the target bytes.
  always_comb begin
    wdata_d = wdata;
    unique case (size)
      SIZE_BYTE: wdata_d = {4{wdata[7:0]}};
      SIZE_HALF: wdata_d = {2{wdata[15:0]}};
      default:   wdata_d = wdata;
    endcase
  end

  dmem_load_align u_align (
    .rdata_i    (ram_rdata),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .result_c_o (load_result_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= SIZE_BYTE;
      off_q       <= 2'b00;
      unsigned_q  <= 1'b0;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            size_q     <= size;
            off_q      <= addr[1:0];
            unsigned_q <= load_unsigned;
            is_load_q  <= mem_read;
            if (access && !bad) begin
              state_q     <= ISSUE;
              ram_en_q    <= 1'b1;
              ram_we_q    <= mem_write ? lane_mask(size, addr[1:0]) : 4'b0000;
              ram_addr_q  <= addr[ADDR_W+1:2];
              ram_wdata_q <= wdata_d;
            end else begin
              // Faulty requests and no-ops skip the RAM and respond straight away.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= access & bad;
            end
          end
        end
        ISSUE: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 4'b0000;
          cnt_q    <= CNT_W'(WAIT_INIT);
          if (!is_load_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else if (RAM_LATENCY > 1) begin
            state_q <= WAIT;
          end else begin
            state_q <= CAPTURE;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= CAPTURE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        CAPTURE: begin
          read_data_q <= load_result_c;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          err_q       <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign err       = err_q;
  assign read_data = read_data_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
